counter_mod: RTL
================

# counter_mod

Parametrised modulo-N up/down counter with clock-enable prescaler, synchronous clear, parallel load and a terminal-count carry for cascading. It generalises the 4-bit enable/clear counter to arbitrary width and modulus, and it adds direction control, load, and a prescaled step rate. Typical use is LED blink/timebase generation and BCD digit chains, where one instance's `tc` drives the next instance's `en`.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits.
- `MODULUS`, 10: count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.
- `PRESCALE`, 1: number of enabled clock cycles per count step; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low.
- `en`, in, 1: count enable; also gates the prescaler.
- `clr`, in, 1: synchronous clear.
- `load`, in, 1: synchronous parallel load.
- `load_value`, in, WIDTH: value to load.
- `up_dn`, in, 1: direction; 1 = up, 0 = down.
- `cnt_value`, out, WIDTH: current count, registered.
- `tc`, out, 1: terminal-count carry, combinational.
- `ovf`, out, 1: sticky saturation flag, registered (see Configuration).

## Operation
- Reset (`rst`=0) sets `cnt_value`=0, prescaler=0, `ovf`=0, asynchronously. `tc` is 0 while in reset.
- Per-edge priority is clr > load > step > hold.
- `clr`=1: `cnt_value`←0, prescaler←0, `ovf`←0.
- `load`=1: `cnt_value`←`load_value`. A value ≥ MODULUS is clamped to MODULUS-1. Also sets prescaler←0 and `ovf`←0.
- `tick` (internal) = `en` & (prescaler == PRESCALE-1).
  - While `en`=1, the prescaler increments and wraps to 0 on `tick`.
  - While `en`=0, the prescaler holds its value.
  - When PRESCALE=1, `tick` = `en`.
- Step on `tick`:
  - Up: `cnt_value`+1, or MODULUS-1 → 0.
  - Down: `cnt_value`-1, or 0 → MODULUS-1.
- Terminal value is MODULUS-1 when counting up and 0 when counting down.
- `tc` = `tick` & (`cnt_value` == terminal) & !`clr` & !`load`. It asserts in the same cycle as the wrapping step, so a downstream counter advances on that same edge.
- `up_dn` is sampled on every edge. Changing direction mid-count takes effect on the next step and does not disturb the prescaler.
- Arithmetic is done in WIDTH+1 bits internally. `cnt_value` never leaves 0..MODULUS-1.

## Timing
- Latency: the first step appears PRESCALE enabled cycles after `en` rises from a cleared state. With PRESCALE=1 the count changes on the first edge with `en`=1.
- `clr` or `load` takes effect on the edge where it is sampled. The first step after it occurs PRESCALE enabled cycles later.
- `rst` deassertion is released synchronously by the integrator. The block requires a clean deassertion and adds no synchroniser.
- `rst` asserted mid-count forces all outputs to their reset values immediately, with no edge required.

## Configuration
- `COUNTER_SAT_EN` defined: saturating mode.
  - A step at the terminal value holds `cnt_value` at the terminal value.
  - `tc` is never asserted.
  - `ovf` is set on the first blocked step and stays set until `clr`, `load` or `rst`.
- `COUNTER_SAT_EN` undefined: wrapping mode as described in Operation. `ovf` is tied to 0.

## Structure
- Shared package `counter_pkg` holds:
  - direction constants `DIR_UP`=1 and `DIR_DN`=0;
  - the `clog2` helper used to size the prescaler;
  - parameter legality checks: elaboration errors when MODULUS is out of range or PRESCALE is 0.
- Sub-module `counter_prescaler` (parameter PRESCALE; ports `clk`, `rst`, `en`, `clr`, `tick`):
  - holds the prescaler register and the tick decode;
  - its `clr` input is driven by `clr | load`.
- `counter_mod` holds the count register, the load clamp, the direction mux, the `tc` decode and the `ovf` flag.

## Test plan
- Wrap up, WIDTH=4, MODULUS=10, PRESCALE=1, `en`=1, `up_dn`=1 for 12 cycles → 0,1,…,9,0,1. `tc`=1 only while `cnt_value`=9.
- Clear and enable, mirroring the legacy counter bench:
  - `clr`=1 for 1 cycle at count 5 → `cnt_value`=0 on the next edge, counting resumes.
  - `en`=0 for 2 cycles → value held.
- Load and clamp:
  - `load_value`=7 with `load`=1 and `en`=1 on the same edge → 7, no step on that edge.
  - `load_value`=15 → clamped to 9.
- Down count and prescaler, PRESCALE=3, `up_dn`=0 from 0 → `cnt_value` becomes 9 after 3 cycles and `tc` pulses once.
  - Then `en`=0 for 2 cycles mid-prescale → the step is delayed by exactly 2 cycles.
- Cascade: two instances (units `tc` → tens `en`), MODULUS=10, run for 100 cycles → tens=0, units=0, and tens `tc` pulsed exactly once.
- Async reset and saturation:
  - `rst`=0 mid-cycle at count 6 → all outputs 0 before the next edge.
  - With `COUNTER_SAT_EN`, count up past 9 → holds at 9 and `ovf`=1; `clr` → `ovf`=0.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the modulo-N counter
// Purpose : direction encodings, clog2 sizing helper and parameter legality
//           predicates shared by counter_mod and counter_prescaler.
// Ports   : none (package).
package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   function automatic bit modulus_ok(input int width, input int modulus);
      return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
   endfunction

   function automatic bit prescale_ok(input int prescale);
      return prescale >= 1;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable-gated prescaler producing the count tick
// Purpose : divides enabled clock cycles by PRESCALE; tick marks the last
//           enabled cycle of each group and the register wraps on it.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-low reset
//           en   - count enable; prescaler holds while low
//           clr  - synchronous restart (driven by clr | load of the counter)
//           tick - combinational step strobe
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   // At least one bit so PRESCALE=1 still has a (constant-zero) register,
   // which makes tick reduce to en without a separate code path.
   localparam int            PW   = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q;

   assign tick = en && (pre_q == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
      end else if (clr || tick) begin
         pre_q <= '0;
      end else if (en) begin
         pre_q <= pre_q + PW'(1);
      end
   end

endmodule

// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - modulo-N up/down counter with prescaler, load and carry
// Purpose : counts 0..MODULUS-1 in either direction at a prescaled rate;
//           tc is the cascade carry asserted on the wrapping step.
// Build   : define COUNTER_SAT_EN for saturating mode (hold at terminal,
//           tc never asserted, sticky ovf); otherwise wrapping, ovf = 0.
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous active-low reset
//           en         - count enable, also gates the prescaler
//           clr        - synchronous clear (highest priority)
//           load       - synchronous parallel load of load_value (clamped)
//           load_value - value to load
//           up_dn      - direction, 1 = up, 0 = down
//           cnt_value  - registered count
//           tc         - combinational terminal-count carry
//           ovf        - registered sticky saturation flag
module counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             up_dn,
   output logic [WIDTH-1:0] cnt_value,
   output logic             tc,
   output logic             ovf
);

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("counter_mod: MODULUS must lie in 2..2**WIDTH");
   end
   if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
      $error("counter_mod: PRESCALE must be at least 1");
   end

   localparam int               XW    = WIDTH + 1;
   localparam logic [XW-1:0]    MOD_X = XW'(MODULUS);
   localparam logic [WIDTH-1:0] TOP_W = WIDTH'(MODULUS - 1);

   logic             tick;
   logic [XW-1:0]    inc_x;
   logic [XW-1:0]    dec_x;
   logic             wrap_up;
   logic             wrap_dn;
   logic             at_term;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] step_w;

   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (clr | load),
      .tick (tick)
   );

   // The extra bit lets the up-wrap be seen as inc == MODULUS (safe even when
   // MODULUS == 2**WIDTH) and the down-wrap as the borrow out of zero.
   always_comb begin
      inc_x        = {1'b0, cnt_value} + XW'(1);
      dec_x        = {1'b0, cnt_value} - XW'(1);
      wrap_up      = (inc_x == MOD_X);
      wrap_dn      = dec_x[WIDTH];
      at_term      = (up_dn == DIR_UP) ? wrap_up : wrap_dn;
      load_clamped = ({1'b0, load_value} >= MOD_X) ? TOP_W : load_value;
      if (up_dn == DIR_UP) begin
         step_w = inc_x[WIDTH-1:0];
      end else begin
         step_w = dec_x[WIDTH-1:0];
      end
      if (at_term) begin
`ifdef COUNTER_SAT_EN
         step_w = cnt_value;
`else
         step_w = (up_dn == DIR_UP) ? '0 : TOP_W;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_value <= '0;
      end else if (clr) begin
         cnt_value <= '0;
      end else if (load) begin
         cnt_value <= load_clamped;
      end else if (tick) begin
         cnt_value <= step_w;
      end
   end

`ifdef COUNTER_SAT_EN
   assign tc = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (clr || load) begin
         ovf <= 1'b0;
      end else if (tick && at_term) begin
         ovf <= 1'b1;
      end
   end
`else
   // rst term keeps tc low during reset even when en would tick at count 0
   // in the down direction.
   assign tc  = rst && tick && at_term && !clr && !load;
   assign ovf = 1'b0;
`endif

endmodule
